axi_err_slave: RTL and testbench
================================

AXI_ERR_SLAVE -- requirements
Module: axi_err_slave

Interface
REQ-001 Parameter IdWidth, default 4, width of AXI ID fields.
REQ-002 Parameter DataWidth, default 32, width of R data.
REQ-003 Parameter logic [DataWidth-1:0] ReadPattern, default 32'hDEAD_BEEF, constant returned on every R beat.
REQ-004 Port clk_i  input  1  the single clock; all state changes on its rising edge.
REQ-005 Port rst_ni  input  1  asynchronous, active-low reset.
REQ-006 Ports awid_i (IdWidth), awlen_i (8), awvalid_i (1) are inputs; awready_o (1) is an output.
REQ-007 Ports wlast_i (1) and wvalid_i (1) are inputs; wready_o (1) is an output; wdata/wstrb are not ports.
REQ-008 Ports bid_o (IdWidth), bresp_o (2) and bvalid_o (1) are outputs; bready_i (1) is an input.
REQ-009 Ports arid_i (IdWidth), arlen_i (8) and arvalid_i (1) are inputs; arready_o (1) is an output.
REQ-010 Ports rid_o (IdWidth), rdata_o (DataWidth), rresp_o (2), rlast_o (1) and rvalid_o (1) are outputs; rready_i (1) is an input.

Function
REQ-011 The block SHALL act as the interconnect default slave, terminating every transaction whose address the address decoder flags as a decode error.
REQ-012 The write FSM SHALL have the states W_IDLE, W_DATA and W_RESP.
REQ-013 The read FSM SHALL have the states R_IDLE and R_DATA.
REQ-014 The write and read FSMs SHALL run independently and concurrently.
REQ-015 In W_IDLE, awready_o=1; on awvalid_i&awready_o, capture awid_i and awlen_i, clear the write beat counter, and go to W_DATA.
REQ-016 In W_DATA, wready_o=1; each wvalid_i handshake increments the beat counter; the handshake with counter==awlen goes to W_RESP.
REQ-017 wlast_i SHALL be ignored for termination; beat count alone ends the burst.
REQ-018 In W_RESP, bvalid_o=1, bresp_o=DECERR (2'b11) and bid_o=captured awid; bvalid_o SHALL be held until bready_i, then go to W_IDLE.
REQ-019 In R_IDLE, arready_o=1; on handshake, capture arid_i and arlen_i, clear the read beat counter, and go to R_DATA.
REQ-020 In R_DATA, rvalid_o=1, rdata_o=ReadPattern, rresp_o=DECERR, rid_o=captured arid, and rlast_o=(counter==captured arlen).
REQ-021 On an rready_i handshake with rlast_o=1, go to R_IDLE; on any other rready_i handshake, increment the counter.
REQ-022 R payload SHALL remain stable while rvalid_o=1 and rready_i=0.
REQ-023 All ready and valid outputs SHALL be decoded from state registers only, with no combinational input-to-output path.
REQ-024 Latency: wready_o rises 1 cycle after the AW handshake, bvalid_o 1 cycle after the final W handshake, and rvalid_o 1 cycle after the AR handshake.
REQ-025 awlen=0 or arlen=0 SHALL be a single-beat burst, and rlast_o=1 on the first beat.
REQ-026 awlen=255 SHALL accept exactly 256 beats; counters are 8 bits and SHALL never wrap within a burst.
REQ-027 No new AW or AR SHALL be accepted until the corresponding FSM returns to idle, giving one outstanding transaction per direction.
REQ-028 The bready_i handshake in W_RESP SHALL return the FSM to W_IDLE; the next AW handshake occurs no earlier than the following cycle.

Reset
REQ-029 While rst_ni=0, both FSMs SHALL be in idle and all counters and captured fields SHALL be 0.
REQ-030 Reset outputs: awready_o=1, arready_o=1, and wready_o=bvalid_o=rvalid_o=rlast_o=0.
REQ-031 Reset outputs: bid_o=rid_o=0, bresp_o=rresp_o=DECERR, and rdata_o=ReadPattern.
REQ-032 Reset asserted mid-burst SHALL abort the transaction immediately, with no response emitted after release.

Structure
REQ-033 The shared package axi_pkg SHALL hold the response enum (OKAY, EXOKAY, SLVERR, DECERR), the burst-length width constant (8), and the FSM state typedefs.
REQ-034 The design SHALL contain no sub-modules; both FSMs are inline.

Verification
REQ-035 AW id=3, len=0, then one W beat, bready=1 -> bvalid_o 1 cycle later with bid_o=3 and bresp_o=2'b11 for 1 cycle.
REQ-036 AR id=5, len=3, rready=1 -> 4 beats of rdata_o=32'hDEAD_BEEF and rresp_o=2'b11, with rlast_o only on beat 4 and arready_o back to 1 next cycle.
REQ-037 AR len=2 with rready toggling 1,0,0,1,1 -> payload stable during stalls, and exactly 3 beats complete.
REQ-038 AW len=255, 256 W beats with wlast_i only on beat 100 -> wready_o is held for all 256 beats, and bvalid_o follows beat 256.
REQ-039 Simultaneous AW id=1, len=1 and AR id=2, len=1 in the same cycle -> both accepted, bid_o=1 and rid_o=2 complete independently, and a second AW while in W_DATA is not accepted.
REQ-040 rst_ni pulsed low during beat 2 of a 4-beat read -> rvalid_o=0 immediately, arready_o=1 after release, and no stray beats.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared AXI definitions: response codes, burst-length width and the
// state encodings of the default-slave write/read FSMs.
package axi_pkg;

    localparam int unsigned LenWidth = 8;

    typedef logic [LenWidth-1:0] len_t;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_e;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } w_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_e;

endpackage

// File: rtl/axi_err_slave_if.sv
// Reduced AXI bundle seen by the error slave: no addresses, no write data,
// only IDs, lengths and handshakes plus the R payload.
interface axi_err_slave_if
    import axi_pkg::*;
#(
    parameter int unsigned IdWidth   = 4,
    parameter int unsigned DataWidth = 32
);
    logic [IdWidth-1:0]   awid;
    len_t                 awlen;
    logic                 awvalid;
    logic                 awready;

    logic                 wlast;
    logic                 wvalid;
    logic                 wready;

    logic [IdWidth-1:0]   bid;
    logic [1:0]           bresp;
    logic                 bvalid;
    logic                 bready;

    logic [IdWidth-1:0]   arid;
    len_t                 arlen;
    logic                 arvalid;
    logic                 arready;

    logic [IdWidth-1:0]   rid;
    logic [DataWidth-1:0] rdata;
    logic [1:0]           rresp;
    logic                 rlast;
    logic                 rvalid;
    logic                 rready;

    modport master (
        output awid, awlen, awvalid, wlast, wvalid, bready,
               arid, arlen, arvalid, rready,
        input  awready, wready, bid, bresp, bvalid,
               arready, rid, rdata, rresp, rlast, rvalid
    );

    modport slave (
        input  awid, awlen, awvalid, wlast, wvalid, bready,
               arid, arlen, arvalid, rready,
        output awready, wready, bid, bresp, bvalid,
               arready, rid, rdata, rresp, rlast, rvalid
    );

endinterface

// File: rtl/axi_err_slave.sv
// Interconnect default slave: swallows every decode-error burst and answers
// DECERR, with independent one-outstanding write and read FSMs.
module axi_err_slave
    import axi_pkg::*;
#(
    parameter int unsigned          IdWidth     = 4,
    parameter int unsigned          DataWidth   = 32,
    parameter logic [DataWidth-1:0] ReadPattern = 32'hDEAD_BEEF
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,

    input  logic [IdWidth-1:0]   awid_i,
    input  logic [7:0]           awlen_i,
    input  logic                 awvalid_i,
    output logic                 awready_o,

    input  logic                 wlast_i,
    input  logic                 wvalid_i,
    output logic                 wready_o,

    output logic [IdWidth-1:0]   bid_o,
    output logic [1:0]           bresp_o,
    output logic                 bvalid_o,
    input  logic                 bready_i,

    input  logic [IdWidth-1:0]   arid_i,
    input  logic [7:0]           arlen_i,
    input  logic                 arvalid_i,
    output logic                 arready_o,

    output logic [IdWidth-1:0]   rid_o,
    output logic [DataWidth-1:0] rdata_o,
    output logic [1:0]           rresp_o,
    output logic                 rlast_o,
    output logic                 rvalid_o,
    input  logic                 rready_i
);

    w_state_e           w_state_q, w_state_d;
    logic [IdWidth-1:0] awid_q, awid_d;
    len_t               awlen_q, awlen_d;
    len_t               wcnt_q, wcnt_d;

    r_state_e           r_state_q, r_state_d;
    logic [IdWidth-1:0] arid_q, arid_d;
    len_t               arlen_q, arlen_d;
    len_t               rcnt_q, rcnt_d;

    // Burst termination is by beat count only, so WLAST carries no information.
    logic unused_wlast;
    assign unused_wlast = wlast_i;

    // ---------------- state registers ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            w_state_q <= W_IDLE;
            awid_q    <= '0;
            awlen_q   <= '0;
            wcnt_q    <= '0;
            r_state_q <= R_IDLE;
            arid_q    <= '0;
            arlen_q   <= '0;
            rcnt_q    <= '0;
        end else begin
            w_state_q <= w_state_d;
            awid_q    <= awid_d;
            awlen_q   <= awlen_d;
            wcnt_q    <= wcnt_d;
            r_state_q <= r_state_d;
            arid_q    <= arid_d;
            arlen_q   <= arlen_d;
            rcnt_q    <= rcnt_d;
        end
    end

    // ---------------- write next-state ----------------
    always_comb begin
        w_state_d = w_state_q;
        awid_d    = awid_q;
        awlen_d   = awlen_q;
        wcnt_d    = wcnt_q;
        unique case (w_state_q)
            W_IDLE: begin
                if (awvalid_i) begin
                    awid_d    = awid_i;
                    awlen_d   = awlen_i;
                    wcnt_d    = '0;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                // Compare before incrementing so a 256-beat burst never wraps.
                if (wvalid_i) begin
                    if (wcnt_q == awlen_q) begin
                        w_state_d = W_RESP;
                    end else begin
                        wcnt_d = wcnt_q + 8'd1;
                    end
                end
            end
            W_RESP: begin
                if (bready_i) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // ---------------- write outputs ----------------
    always_comb begin
        awready_o = (w_state_q == W_IDLE);
        wready_o  = (w_state_q == W_DATA);
        bvalid_o  = (w_state_q == W_RESP);
        bid_o     = awid_q;
        bresp_o   = DECERR;
    end

    // ---------------- read next-state ----------------
    always_comb begin
        r_state_d = r_state_q;
        arid_d    = arid_q;
        arlen_d   = arlen_q;
        rcnt_d    = rcnt_q;
        unique case (r_state_q)
            R_IDLE: begin
                if (arvalid_i) begin
                    arid_d    = arid_i;
                    arlen_d   = arlen_i;
                    rcnt_d    = '0;
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (rready_i) begin
                    if (rcnt_q == arlen_q) begin
                        r_state_d = R_IDLE;
                    end else begin
                        rcnt_d = rcnt_q + 8'd1;
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // ---------------- read outputs ----------------
    always_comb begin
        arready_o = (r_state_q == R_IDLE);
        rvalid_o  = (r_state_q == R_DATA);
        rlast_o   = (r_state_q == R_DATA) && (rcnt_q == arlen_q);
        rid_o     = arid_q;
        rdata_o   = ReadPattern;
        rresp_o   = DECERR;
    end

endmodule

// File: tb/tb_axi_err_slave.sv
// Directed bench for the AXI default slave; outputs are checked on the
// falling edge and inputs are changed there too.
module tb_axi_err_slave;
    import axi_pkg::*;

    localparam int unsigned IdW = 4;
    localparam int unsigned DW  = 32;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    axi_err_slave_if #(.IdWidth(IdW), .DataWidth(DW)) bus ();

    axi_err_slave #(
        .IdWidth    (IdW),
        .DataWidth  (DW),
        .ReadPattern(32'hDEAD_BEEF)
    ) dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .awid_i   (bus.awid),
        .awlen_i  (bus.awlen),
        .awvalid_i(bus.awvalid),
        .awready_o(bus.awready),
        .wlast_i  (bus.wlast),
        .wvalid_i (bus.wvalid),
        .wready_o (bus.wready),
        .bid_o    (bus.bid),
        .bresp_o  (bus.bresp),
        .bvalid_o (bus.bvalid),
        .bready_i (bus.bready),
        .arid_i   (bus.arid),
        .arlen_i  (bus.arlen),
        .arvalid_i(bus.arvalid),
        .arready_o(bus.arready),
        .rid_o    (bus.rid),
        .rdata_o  (bus.rdata),
        .rresp_o  (bus.rresp),
        .rlast_o  (bus.rlast),
        .rvalid_o (bus.rvalid),
        .rready_i (bus.rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_awready"}, 64'(bus.awready), 64'd1);
        chk({tag, "_arready"}, 64'(bus.arready), 64'd1);
        chk({tag, "_wready"},  64'(bus.wready),  64'd0);
        chk({tag, "_bvalid"},  64'(bus.bvalid),  64'd0);
        chk({tag, "_rvalid"},  64'(bus.rvalid),  64'd0);
        chk({tag, "_rlast"},   64'(bus.rlast),   64'd0);
    endtask

    task automatic chk_rbeat(input string tag, input logic [3:0] id, input logic last);
        chk({tag, "_rvalid"}, 64'(bus.rvalid), 64'd1);
        chk({tag, "_rdata"},  64'(bus.rdata),  64'hDEAD_BEEF);
        chk({tag, "_rresp"},  64'(bus.rresp),  64'd3);
        chk({tag, "_rid"},    64'(bus.rid),    64'(id));
        chk({tag, "_rlast"},  64'(bus.rlast),  64'(last));
    endtask

    int beats;

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        bus.awid = '0; bus.awlen = '0; bus.awvalid = 1'b0;
        bus.wlast = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b0;
        bus.arid = '0; bus.arlen = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;

        // Reset values
        @(negedge clk);
        @(negedge clk);
        chk_idle("rst");
        chk("rst_bid",   64'(bus.bid),   64'd0);
        chk("rst_rid",   64'(bus.rid),   64'd0);
        chk("rst_bresp", 64'(bus.bresp), 64'd3);
        chk("rst_rresp", 64'(bus.rresp), 64'd3);
        chk("rst_rdata", 64'(bus.rdata), 64'hDEAD_BEEF);
        rst_n = 1'b1;
        step();
        $display("reset released: checks=%0d", checks);

        // Single-beat write, id 3
        bus.awvalid = 1'b1; bus.awid = 4'd3; bus.awlen = 8'd0;
        step();
        bus.awvalid = 1'b0;
        chk("w1_wready",  64'(bus.wready),  64'd1);
        chk("w1_awready", 64'(bus.awready), 64'd0);
        chk("w1_bvalid0", 64'(bus.bvalid),  64'd0);
        bus.wvalid = 1'b1;
        step();
        bus.wvalid = 1'b0;
        chk("w1_bvalid", 64'(bus.bvalid), 64'd1);
        chk("w1_bid",    64'(bus.bid),    64'd3);
        chk("w1_bresp",  64'(bus.bresp),  64'd3);
        chk("w1_wready0", 64'(bus.wready), 64'd0);
        bus.bready = 1'b1;
        step();
        bus.bready = 1'b0;
        chk_idle("w1_done");
        $display("write id3 len0: checks=%0d errors=%0d", checks, errors);

        // Four-beat read, id 5, rready held high
        bus.arvalid = 1'b1; bus.arid = 4'd5; bus.arlen = 8'd3; bus.rready = 1'b1;
        step();
        bus.arvalid = 1'b0;
        for (int b = 0; b < 4; b++) begin
            chk_rbeat($sformatf("r4_beat%0d", b), 4'd5, (b == 3));
            chk("r4_arready_busy", 64'(bus.arready), 64'd0);
            step();
        end
        bus.rready = 1'b0;
        chk_idle("r4_done");
        $display("read id5 len3: checks=%0d errors=%0d", checks, errors);

        // Three-beat read with rready pattern 1,0,0,1,1
        bus.arvalid = 1'b1; bus.arid = 4'd6; bus.arlen = 8'd2;
        step();
        bus.arvalid = 1'b0;
        beats = 0;
        for (int c = 0; c < 5; c++) begin
            logic [4:0] pat;
            pat = 5'b11001;
            bus.rready = pat[c];
            chk_rbeat($sformatf("r3_cyc%0d", c), 4'd6, (beats == 2));
            if (bus.rready) beats++;
            step();
        end
        bus.rready = 1'b0;
        chk("r3_beats", 64'(beats), 64'd3);
        chk_idle("r3_done");
        $display("read id6 len2 stalled: checks=%0d errors=%0d", checks, errors);

        // 256-beat write, wlast only on beat 100
        bus.awvalid = 1'b1; bus.awid = 4'd9; bus.awlen = 8'd255;
        step();
        bus.awvalid = 1'b0;
        for (int i = 0; i < 256; i++) begin
            chk($sformatf("w256_wready%0d", i), 64'(bus.wready), 64'd1);
            chk($sformatf("w256_bvalid%0d", i), 64'(bus.bvalid), 64'd0);
            bus.wvalid = 1'b1;
            bus.wlast  = (i == 99);
            step();
        end
        bus.wvalid = 1'b0;
        bus.wlast  = 1'b0;
        chk("w256_bvalid", 64'(bus.bvalid), 64'd1);
        chk("w256_bid",    64'(bus.bid),    64'd9);
        chk("w256_wready", 64'(bus.wready), 64'd0);
        step();
        chk("w256_bhold", 64'(bus.bvalid), 64'd1);
        bus.bready = 1'b1;
        step();
        bus.bready = 1'b0;
        chk_idle("w256_done");
        $display("write id9 len255: checks=%0d errors=%0d", checks, errors);

        // Concurrent AW id1/AR id2, both len 1; extra AW during W_DATA
        bus.awvalid = 1'b1; bus.awid = 4'd1; bus.awlen = 8'd1;
        bus.arvalid = 1'b1; bus.arid = 4'd2; bus.arlen = 8'd1;
        step();
        bus.arvalid = 1'b0;
        bus.awid = 4'd7;
        chk("cc_awready", 64'(bus.awready), 64'd0);
        chk("cc_arready", 64'(bus.arready), 64'd0);
        chk("cc_wready",  64'(bus.wready),  64'd1);
        chk_rbeat("cc_r0", 4'd2, 1'b0);
        bus.wvalid = 1'b1;
        step();
        chk("cc_awready2", 64'(bus.awready), 64'd0);
        chk("cc_wready2",  64'(bus.wready),  64'd1);
        chk_rbeat("cc_r0_stall", 4'd2, 1'b0);
        step();
        bus.wvalid = 1'b0;
        chk("cc_bvalid", 64'(bus.bvalid), 64'd1);
        chk("cc_bid",    64'(bus.bid),    64'd1);
        bus.bready = 1'b1;
        bus.rready = 1'b1;
        step();
        chk("cc_bvalid0", 64'(bus.bvalid), 64'd0);
        chk("cc_awready3", 64'(bus.awready), 64'd1);
        chk_rbeat("cc_r1", 4'd2, 1'b1);
        bus.awvalid = 1'b0;
        bus.bready  = 1'b0;
        step();
        bus.rready = 1'b0;
        chk_idle("cc_done");
        chk("cc_bid_kept", 64'(bus.bid), 64'd1);
        $display("concurrent aw/ar: checks=%0d errors=%0d", checks, errors);

        // Reset pulse during beat 2 of a 4-beat read
        bus.arvalid = 1'b1; bus.arid = 4'd4; bus.arlen = 8'd3; bus.rready = 1'b1;
        step();
        bus.arvalid = 1'b0;
        chk_rbeat("rr_beat0", 4'd4, 1'b0);
        step();
        chk_rbeat("rr_beat1", 4'd4, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("rr_rvalid_async", 64'(bus.rvalid),  64'd0);
        chk("rr_arready_async", 64'(bus.arready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk_idle($sformatf("rr_after%0d", k));
            chk($sformatf("rr_rid%0d", k), 64'(bus.rid), 64'd0);
            step();
        end
        bus.rready = 1'b0;
        $display("reset mid-read: checks=%0d errors=%0d", checks, errors);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
